// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic valid/ready pipeline-stage register (1-entry latch or 2-entry skid buffer)
//
// Optional feature macro: PIPE_STAGE_PERF_EN (enables stall/bubble performance counters)
//
// Parameters:
//    DATA_W      payload width in bits
//    DEPTH       storage entries: 1 (plain latch) or 2 (skid buffer)
//    BUBBLE_VAL  payload presented on out_data whenever out_valid=0
//    CNT_W       performance counter width
//
// Ports:
//    CLK         clock, rising edge
//    nRST        asynchronous active-low reset
//    in_valid    upstream has an item
//    in_ready    stage can accept an item this cycle
//    in_data     upstream payload
//    squash_in   accepted item is discarded (bubble inserted in its place)
//    flush       synchronous clear of all entries
//    out_valid   head entry is valid
//    out_ready   downstream consumes the head this cycle
//    out_data    head payload, BUBBLE_VAL when empty
//    occ         number of occupied entries
//    stall_cnt   cycles with out_valid & ~out_ready (saturating)
//    bubble_cnt  cycles with out_ready & ~out_valid plus squashed items (saturating)

module pipe_stage_buf #(
   parameter int                DATA_W     = 128,
   parameter int                DEPTH      = 2,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
   parameter int                CNT_W      = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              squash_in,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   generate
      if (DEPTH != 1 && DEPTH != 2) begin : g_bad_depth
         $fatal(1, "pipe_stage_buf: DEPTH must be 1 or 2");
      end
   endgenerate

   // Occupancy state; the encoding doubles as the occ output.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_state_t;

   occ_state_t        state_q, state_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] skid_q, skid_d;

   logic accept;
   logic push;
   logic pop;
   logic squashed;

   assign out_valid = (state_q != ST_EMPTY);
   // Head register is forced to BUBBLE_VAL whenever it empties, so no output mux is needed.
   assign out_data  = head_q;
   assign occ       = state_q;

   // DEPTH=1 may look through to out_ready; DEPTH=2 uses registered state only so
   // in_ready never depends combinationally on out_ready.
   always_comb begin
      in_ready = 1'b1;
      if (DEPTH == 1) begin
         in_ready = ~out_valid | out_ready;
      end else begin
         in_ready = (state_q != ST_FULL);
      end
   end

   assign accept   = in_valid & in_ready;
   assign squashed = accept & squash_in;
   assign push     = accept & ~squash_in & ~flush;
   assign pop      = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         head_d  = BUBBLE_VAL;
         skid_d  = BUBBLE_VAL;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  head_d  = in_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  head_d = in_data;
               end else if (push && DEPTH == 2) begin
                  skid_d  = in_data;
                  state_d = ST_FULL;
               end else if (pop) begin
                  head_d  = BUBBLE_VAL;
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a pop can occur.
               if (pop) begin
                  head_d  = skid_q;
                  skid_d  = BUBBLE_VAL;
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               head_d  = BUBBLE_VAL;
               skid_d  = BUBBLE_VAL;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= ST_EMPTY;
         head_q  <= BUBBLE_VAL;
         skid_q  <= BUBBLE_VAL;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] stall_q, bubble_q;
   logic             stall_inc;
   logic [1:0]       bubble_inc;
   logic [CNT_W:0]   stall_sum, bubble_sum;

   assign stall_inc  = out_valid & ~out_ready;
   // An idle downstream cycle and a squashed item in the same cycle count twice.
   assign bubble_inc = {1'b0, out_ready & ~out_valid} + {1'b0, squashed};

   assign stall_sum  = {1'b0, stall_q} + {{CNT_W{1'b0}}, stall_inc};
   assign bubble_sum = {1'b0, bubble_q} + {{(CNT_W-1){1'b0}}, bubble_inc};

   // Counters survive flush; only reset clears them.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         stall_q  <= (stall_sum > {1'b0, CNT_MAX}) ? CNT_MAX : stall_sum[CNT_W-1:0];
         bubble_q <= (bubble_sum > {1'b0, CNT_MAX}) ? CNT_MAX : bubble_sum[CNT_W-1:0];
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf (DEPTH=2 and DEPTH=1 instances)

module tb_pipe_stage_buf;

   localparam int DW = 8;
   localparam int CW = 4;
`ifdef PIPE_STAGE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          CLK;
   logic          nRST;

   logic          iv0, sq0, fl0, or0;
   logic [DW-1:0] d0;
   logic          ir0, ov0;
   logic [DW-1:0] od0;
   logic [1:0]    occ0;
   logic [CW-1:0] sc0, bc0;

   logic          iv1, sq1, fl1, or1;
   logic [DW-1:0] d1;
   logic          ir1, ov1;
   logic [DW-1:0] od1;
   logic [1:0]    occ1;
   logic [CW-1:0] sc1, bc1;

   pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .BUBBLE_VAL('0), .CNT_W(CW)) u_d2 (
      .CLK(CLK), .nRST(nRST),
      .in_valid(iv0), .in_ready(ir0), .in_data(d0),
      .squash_in(sq0), .flush(fl0),
      .out_valid(ov0), .out_ready(or0), .out_data(od0),
      .occ(occ0), .stall_cnt(sc0), .bubble_cnt(bc0)
   );

   pipe_stage_buf #(.DATA_W(DW), .DEPTH(1), .BUBBLE_VAL('0), .CNT_W(CW)) u_d1 (
      .CLK(CLK), .nRST(nRST),
      .in_valid(iv1), .in_ready(ir1), .in_data(d1),
      .squash_in(sq1), .flush(fl1),
      .out_valid(ov1), .out_ready(or1), .out_data(od1),
      .occ(occ1), .stall_cnt(sc1), .bubble_cnt(bc1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic          iv;
      logic [DW-1:0] d;
      logic          sq;
      logic          fl;
      logic          ordy;
      logic          e_ir;
      logic          e_ov;
      logic [DW-1:0] e_od;
      logic [1:0]    e_occ;
   } vec_t;

   vec_t tab0[20];
   vec_t tab1[7];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic sq,
                               input logic fl, input logic ordy, input logic e_ir,
                               input logic e_ov, input logic [DW-1:0] e_od,
                               input logic [1:0] e_occ);
      vec_t v;
      v.iv = iv; v.d = d; v.sq = sq; v.fl = fl; v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_all();
      iv0 = 0; d0 = '0; sq0 = 0; fl0 = 0; or0 = 0;
      iv1 = 0; d1 = '0; sq1 = 0; fl1 = 0; or1 = 0;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      cyc();
      nRST = 1'b1;
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int sel, input string tag);
      if (sel == 0) begin
         iv0 = v.iv; d0 = v.d; sq0 = v.sq; fl0 = v.fl; or0 = v.ordy;
      end else begin
         iv1 = v.iv; d1 = v.d; sq1 = v.sq; fl1 = v.fl; or1 = v.ordy;
      end
      #1;
      check({tag, ".in_ready"}, (sel == 0) ? ir0 : ir1, v.e_ir);
      cyc();
      check({tag, ".out_valid"}, (sel == 0) ? ov0 : ov1, v.e_ov);
      check({tag, ".out_data"}, (sel == 0) ? od0 : od1, v.e_od);
      check({tag, ".occ"}, (sel == 0) ? occ0 : occ1, v.e_occ);
   endtask

   initial begin
      //                  iv d      sq fl or  ir ov od     occ
      // streaming, out_ready held high
      tab0[0]  = mk(1, 8'hA1, 0, 0, 1,  1, 1, 8'hA1, 2'd1);
      tab0[1]  = mk(1, 8'hA2, 0, 0, 1,  1, 1, 8'hA2, 2'd1);
      tab0[2]  = mk(1, 8'hA3, 0, 0, 1,  1, 1, 8'hA3, 2'd1);
      tab0[3]  = mk(0, 8'h00, 0, 0, 1,  1, 0, 8'h00, 2'd0);
      // back-pressure fills the skid entry, then drains in order
      tab0[4]  = mk(1, 8'hB1, 0, 0, 0,  1, 1, 8'hB1, 2'd1);
      tab0[5]  = mk(1, 8'hB2, 0, 0, 0,  1, 1, 8'hB1, 2'd2);
      tab0[6]  = mk(1, 8'hB3, 0, 0, 0,  0, 1, 8'hB1, 2'd2);
      tab0[7]  = mk(0, 8'h00, 0, 0, 1,  0, 1, 8'hB2, 2'd1);
      tab0[8]  = mk(0, 8'h00, 0, 0, 1,  1, 0, 8'h00, 2'd0);
      // flush while full with a pending item, then flush with an accepted push
      tab0[9]  = mk(1, 8'hC1, 0, 0, 0,  1, 1, 8'hC1, 2'd1);
      tab0[10] = mk(1, 8'hC2, 0, 0, 0,  1, 1, 8'hC1, 2'd2);
      tab0[11] = mk(1, 8'hC3, 0, 1, 0,  0, 0, 8'h00, 2'd0);
      tab0[12] = mk(0, 8'h00, 0, 0, 0,  1, 0, 8'h00, 2'd0);
      tab0[13] = mk(1, 8'hC4, 0, 0, 0,  1, 1, 8'hC4, 2'd1);
      tab0[14] = mk(1, 8'hC5, 0, 1, 0,  1, 0, 8'h00, 2'd0);
      // squash on empty stage, squash coincident with pop
      tab0[15] = mk(1, 8'hD1, 1, 0, 0,  1, 0, 8'h00, 2'd0);
      tab0[16] = mk(1, 8'hE1, 0, 0, 0,  1, 1, 8'hE1, 2'd1);
      tab0[17] = mk(1, 8'hD2, 1, 0, 1,  1, 0, 8'h00, 2'd0);
      tab0[18] = mk(1, 8'hE2, 0, 0, 1,  1, 1, 8'hE2, 2'd1);
      tab0[19] = mk(0, 8'h00, 0, 0, 1,  1, 0, 8'h00, 2'd0);

      // DEPTH=1: in_ready looks through to out_ready
      tab1[0]  = mk(1, 8'h11, 0, 0, 0,  1, 1, 8'h11, 2'd1);
      tab1[1]  = mk(1, 8'h12, 0, 0, 0,  0, 1, 8'h11, 2'd1);
      tab1[2]  = mk(1, 8'h12, 0, 0, 1,  1, 1, 8'h12, 2'd1);
      tab1[3]  = mk(0, 8'h00, 0, 0, 1,  1, 0, 8'h00, 2'd0);
      tab1[4]  = mk(1, 8'h13, 1, 0, 0,  1, 0, 8'h00, 2'd0);
      tab1[5]  = mk(1, 8'h14, 0, 0, 0,  1, 1, 8'h14, 2'd1);
      tab1[6]  = mk(1, 8'h15, 0, 1, 1,  1, 0, 8'h00, 2'd0);

      idle_all();
      nRST = 1'b0;
      #1;
      check("reset.out_valid", ov0, 0);
      check("reset.occ", occ0, 0);
      check("reset.out_data", od0, 0);
      check("reset.in_ready", ir0, 1);
      check("reset.stall_cnt", sc0, 0);
      check("reset.bubble_cnt", bc0, 0);
      cyc();
      nRST = 1'b1;
      #1;

      for (int i = 0; i < 20; i++) run_vec(tab0[i], 0, $sformatf("d2[%0d]", i));
      idle_all();

      // counters: squash, stall saturation, double bubble increment, bubble saturation, flush retention
      do_reset();
      cyc();
      check("cnt.idle_stall", sc0, 0);
      check("cnt.idle_bubble", bc0, 0);
      iv0 = 1; d0 = 8'hD1; sq0 = 1; or0 = 0;
      #1;
      check("cnt.squash_ready", ir0, 1);
      cyc();
      check("cnt.squash_occ", occ0, 0);
      check("cnt.squash_bubble", bc0, PERF ? 1 : 0);
      iv0 = 1; d0 = 8'hF1; sq0 = 0; or0 = 0;
      cyc();
      iv0 = 0;
      repeat (20) cyc();
      check("cnt.stall_sat", sc0, PERF ? 15 : 0);
      check("cnt.stall_hold_data", od0, 8'hF1);
      check("cnt.stall_hold_occ", occ0, 1);
      or0 = 1;
      cyc();
      check("cnt.pop_occ", occ0, 0);
      iv0 = 1; d0 = 8'hD3; sq0 = 1; or0 = 1;
      cyc();
      check("cnt.bubble_plus2", bc0, PERF ? 3 : 0);
      iv0 = 0; sq0 = 0;
      repeat (20) cyc();
      check("cnt.bubble_sat", bc0, PERF ? 15 : 0);
      or0 = 0; fl0 = 1;
      cyc();
      fl0 = 0;
      check("cnt.flush_keep_stall", sc0, PERF ? 15 : 0);
      check("cnt.flush_keep_bubble", bc0, PERF ? 15 : 0);

      // asynchronous reset mid-stream with the stage full
      iv0 = 1; d0 = 8'h61; or0 = 0;
      cyc();
      d0 = 8'h62;
      cyc();
      iv0 = 0;
      check("areset.pre_occ", occ0, 2);
      #2;
      nRST = 1'b0;
      #1;
      check("areset.out_valid", ov0, 0);
      check("areset.occ", occ0, 0);
      check("areset.out_data", od0, 0);
      check("areset.stall_cnt", sc0, 0);
      check("areset.bubble_cnt", bc0, 0);
      cyc();
      nRST = 1'b1;
      #1;
      check("areset.in_ready", ir0, 1);

      for (int i = 0; i < 7; i++) run_vec(tab1[i], 1, $sformatf("d1[%0d]", i));
      idle_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
